// File: rtl/decompress_stream.sv
// decompress_stream: Kyber coefficient decompression round(Q*y/2^d) on a valid/ready stream.
// Optional DECOMP_RANGE_CHECK_EN: flag err when accepted in_data has bits set at or above bit d.
module decompress_stream #(
    parameter int N_COEF = 256,
    parameter int Q      = 3329
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  d_sel,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  dbg_state
);

    // Both streams are valid/ready: a transfer occurs on a rising edge with valid and ready
    // both high; a raised valid holds, with its data unchanged, until that transfer.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [8:0] LAST = 9'(N_COEF - 1);

    state_t      state, state_nxt;
    logic [3:0]  d_q;
    logic [8:0]  in_cnt, out_cnt;
    logic        d_legal, in_hs, out_hs, last_in, last_out;
    logic [11:0] mask, ym, result;
    logic [23:0] prod, rnd, sum;

    assign d_legal   = (d_sel != 4'd0) && (d_sel <= 4'd12);
    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign last_in   = in_hs && (in_cnt == LAST);
    assign last_out  = out_hs && (out_cnt == LAST);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // For d=12 the shifted one falls off the top and the subtraction wraps to all ones.
    assign mask   = (12'd1 << d_q) - 12'd1;
    assign ym     = in_data & mask;
    assign prod   = 24'(Q) * {12'd0, ym};
    assign rnd    = (d_q == 4'd0) ? 24'd0 : (24'd1 << (d_q - 4'd1));
    assign sum    = prod + rnd;
    assign result = 12'(sum >> d_q);

`ifdef DECOMP_RANGE_CHECK_EN
    logic range_bad;
    assign range_bad = |(in_data & ~mask);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && d_legal) state_nxt = RUN;
            RUN:     if (last_in) state_nxt = DRAIN;
            DRAIN:   if (last_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q       <= 4'd0;
            in_cnt    <= 9'd0;
            out_cnt   <= 9'd0;
            out_valid <= 1'b0;
            out_data  <= 16'd0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= (state == DRAIN) && last_out;
            if (state == IDLE && start) begin
                if (d_legal) begin
                    d_q     <= d_sel;
                    in_cnt  <= 9'd0;
                    out_cnt <= 9'd0;
                    err     <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end
            // A new result overwrites the slot in the same edge the old one leaves.
            if (in_hs) begin
                in_cnt    <= in_cnt + 9'd1;
                out_valid <= 1'b1;
                out_data  <= {4'd0, result};
`ifdef DECOMP_RANGE_CHECK_EN
                if (range_bad) err <= 1'b1;
`endif
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
            if (out_hs) out_cnt <= out_cnt + 9'd1;
        end
    end

endmodule

// File: doc/decompress_stream.md
DECOMPRESS_STREAM -- requirements
Module: decompress_stream

Interface
REQ-001 Parameter N_COEF, default 256, number of coefficients per frame.
REQ-002 Parameter Q, default 3329, Kyber modulus.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  one-cycle frame start; d_sel sampled in the same cycle.
REQ-006 Port d_sel  input  4  compression width d for the frame; legal values 1..12.
REQ-007 Port in_valid  input  1  compressed coefficient valid.
REQ-008 Port in_ready  output  1  block accepts the coefficient this cycle.
REQ-009 Port in_data  input  12  compressed coefficient y; only bits [d-1:0] are significant.
REQ-010 Port out_valid  output  1  decompressed coefficient valid.
REQ-011 Port out_ready  input  1  downstream accepts the coefficient.
REQ-012 Port out_data  output  16  decompressed coefficient; bits [15:12] always 0.
REQ-013 Port busy  output  1  high while a frame is in progress.
REQ-014 Port done  output  1  one-cycle pulse at frame completion.
REQ-015 Port err  output  1  sticky error flag.

Function
REQ-016 Arithmetic: out_data = (Q*ym + 2^(d-1)) >> d, with ym = in_data mod 2^d; 24-bit product, no overflow; result always < Q.
REQ-017 FSM states IDLE, RUN, DRAIN; reset state IDLE.
REQ-018 IDLE -> RUN on start with legal d_sel; d is latched, in/out counters cleared, err cleared.
REQ-019 start with d_sel of 0 or >12 in IDLE: stays IDLE, err set.
REQ-020 start while busy: ignored, latched d unchanged.
REQ-021 in_ready = (state==RUN) and (!out_valid or out_ready).
REQ-022 Input handshake (in_valid and in_ready): result registered into out_data, out_valid set next cycle; latency exactly 1 cycle.
REQ-023 out_valid/out_data hold stable while out_valid and !out_ready.
REQ-024 Simultaneous output handshake and input handshake: out_valid stays high with the new value; zero bubbles, full throughput of 1 coefficient/cycle.
REQ-025 RUN -> DRAIN on the N_COEF-th input handshake; in_ready low in DRAIN.
REQ-026 DRAIN -> IDLE on the N_COEF-th output handshake; done pulses high in the cycle after that handshake; busy low from that same cycle.
REQ-027 busy = (state != IDLE).
REQ-028 Input and output counters 9 bits each; they do not wrap within a frame.

Reset
REQ-029 rst_n low: state IDLE, counters 0, latched d 0, out_valid 0, out_data 0, in_ready 0, busy 0, done 0, err 0, immediately and asynchronously.
REQ-030 Reset mid-frame abandons the frame; no done pulse; the next frame starts only with a new start.

Configuration
REQ-031 Macro DECOMP_RANGE_CHECK_EN defined: an accepted in_data with any bit at or above bit d set sets err (sticky until next legal start); the coefficient is still processed using ym.
REQ-032 Macro undefined: upper bits silently masked; err set only by an illegal d_sel.

Verification
REQ-033 d=1, inputs 0,1 -> outputs 0, 1665.
REQ-034 d=4, y=15 -> 3121; d=10, y=1023 -> 3326; d=11, y=2047 -> 3327; d=10, y=0 -> 0.
REQ-035 d=10, 256 back-to-back inputs with out_ready=1 -> 256 outputs on consecutive cycles; done pulses once, 1 cycle after the last output; busy then low.
REQ-036 out_ready held low 5 cycles mid-frame -> out_data stable, in_ready low, no loss or duplication; all 256 outputs in order.
REQ-037 start with d_sel=13 -> stays IDLE, err=1; a later start with d_sel=4 clears err; a start asserted mid-frame is ignored.
REQ-038 rst_n asserted after 100 coefficients -> all outputs 0 at once, no done; a new frame of 256 completes normally; with DECOMP_RANGE_CHECK_EN, d=4, y=0x010 -> err=1, out_data=0.
